// File: rtl/tpm_if_arbiter_pkg.sv
// Shared types and constants for the two-requester TPM provider arbiter.
package tpm_if_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OWN,
        ST_WR,
        ST_RD,
        ST_RDH
    } state_e;

    localparam logic [7:0] READ_ABORT_BYTE = 8'hFF;

endpackage

// File: rtl/tpm_if_arbiter_rr.sv
// Two-way round-robin picker: on a tie the requester other than `last_i` wins.
module tpm_arb_rr (
    input  logic [1:0] active_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        unique case (active_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = '0;
        endcase
    end

endmodule

// File: rtl/tpm_if_arbiter.sv
// Arbitrates LPC (0) and SPI (1) peripherals onto one TPM register data provider,
// with per-requester pending slots and a provider watchdog.
module tpm_if_arbiter
    import tpm_if_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_active_i,
    input  logic [31:0] req_addr_i,
    input  logic [15:0] req_data_i,
    input  logic [1:0]  req_data_wr_i,
    output logic [1:0]  req_wr_done_o,
    output logic [7:0]  req_data_o,
    input  logic [1:0]  req_data_req_i,
    output logic [1:0]  req_data_rd_o,
    output logic [15:0] p_addr_o,
    output logic [7:0]  p_data_o,
    output logic        p_data_wr_o,
    input  logic        p_wr_done_i,
    input  logic [7:0]  p_data_i,
    input  logic        p_data_rd_i,
    output logic        p_data_req_o,
    output logic [1:0]  grant_o,
    output logic        timeout_o,
    output logic        overflow_o
);

    state_e            state_q;
    logic [1:0]        grant_q;
    logic              last_q;
    logic [1:0]        wr_hist_q, rd_hist_q;
    logic [1:0]        pend_wr_q, pend_rd_q, pend_wr_d, pend_rd_d;
    logic [1:0][15:0]  wr_addr_q, rd_addr_q;
    logic [1:0][7:0]   wr_data_q;
    logic [CNT_W-1:0]  wd_q;
    logic [15:0]       p_addr_q;
    logic [7:0]        p_data_q, rdata_q;
    logic              p_wr_q, p_req_q, timeout_q, overflow_q;
    logic [1:0]        wr_done_q, rd_q;

    logic [1:0] pick, wr_edge, rd_edge, wr_take, rd_take;
    logic       g, serve_wr, serve_rd, wd_exp, ovf_set;

    tpm_arb_rr u_rr (
        .active_i (req_active_i),
        .last_i   (last_q),
        .grant_o  (pick)
    );

    assign g        = grant_q[1];
    assign wr_edge  = req_data_wr_i & ~wr_hist_q;
    assign rd_edge  = req_data_req_i & ~rd_hist_q;
    assign serve_wr = (state_q == ST_OWN) && pend_wr_q[g];
    assign serve_rd = (state_q == ST_OWN) && !pend_wr_q[g] && pend_rd_q[g];
    assign wd_exp   = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Every strobe, owner or not, lands in its slot; OWN serves the owner's slots,
    // so a slot freed this cycle can accept a fresh strobe in the same cycle.
    always_comb begin
        pend_wr_d = pend_wr_q;
        pend_rd_d = pend_rd_q;
        wr_take   = '0;
        rd_take   = '0;
        ovf_set   = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (grant_q[i] && serve_wr) pend_wr_d[i] = 1'b0;
            if (grant_q[i] && serve_rd) pend_rd_d[i] = 1'b0;
            if (wr_edge[i]) begin
                if (pend_wr_d[i]) ovf_set = 1'b1;
                else begin
                    pend_wr_d[i] = 1'b1;
                    wr_take[i]   = 1'b1;
                end
            end
            if (rd_edge[i]) begin
                if (pend_rd_d[i]) ovf_set = 1'b1;
                else begin
                    pend_rd_d[i] = 1'b1;
                    rd_take[i]   = 1'b1;
                end
            end
            if (!req_active_i[i] && !grant_q[i]) begin
                pend_wr_d[i] = 1'b0;
                pend_rd_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= 1'b1;
            wr_hist_q  <= '0;
            rd_hist_q  <= '0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_data_q  <= '0;
            wd_q       <= '0;
            p_addr_q   <= '0;
            p_data_q   <= '0;
            rdata_q    <= '0;
            p_wr_q     <= 1'b0;
            p_req_q    <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            wr_done_q  <= '0;
            rd_q       <= '0;
        end else begin
            wr_hist_q <= req_data_wr_i;
            rd_hist_q <= req_data_req_i;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            wr_done_q <= '0;
            timeout_q <= 1'b0;
            if (ovf_set) overflow_q <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (wr_take[i]) begin
                    wr_addr_q[i] <= req_addr_i[16*i +: 16];
                    wr_data_q[i] <= req_data_i[8*i +: 8];
                end
                if (rd_take[i]) rd_addr_q[i] <= req_addr_i[16*i +: 16];
            end

            case (state_q)
                ST_IDLE: begin
                    if (|req_active_i) begin
                        grant_q <= pick;
                        state_q <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (serve_wr) begin
                        p_addr_q <= wr_addr_q[g];
                        p_data_q <= wr_data_q[g];
                        p_wr_q   <= 1'b1;
                        wd_q     <= '0;
                        state_q  <= ST_WR;
                    end else if (serve_rd) begin
                        p_addr_q <= rd_addr_q[g];
                        p_req_q  <= 1'b1;
                        wd_q     <= '0;
                        state_q  <= ST_RD;
                    end else if (!req_active_i[g]) begin
                        last_q  <= g;
                        grant_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (p_wr_done_i || wd_exp) begin
                        p_wr_q       <= 1'b0;
                        timeout_q    <= !p_wr_done_i;
                        wr_done_q[g] <= req_active_i[g];
                        state_q      <= ST_OWN;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_RD: begin
                    if (p_data_rd_i || wd_exp) begin
                        p_req_q   <= 1'b0;
                        timeout_q <= !p_data_rd_i;
                        // A requester whose frame already ended gets no read strobe.
                        if (req_active_i[g]) begin
                            rdata_q <= p_data_rd_i ? p_data_i : READ_ABORT_BYTE;
                            rd_q[g] <= 1'b1;
                            state_q <= ST_RDH;
                        end else begin
                            state_q <= ST_OWN;
                        end
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_RDH: begin
                    if (!req_data_req_i[g] || !req_active_i[g]) begin
                        rd_q    <= '0;
                        state_q <= ST_OWN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_wr_done_o = wr_done_q;
    assign req_data_o    = rdata_q;
    assign req_data_rd_o = rd_q;
    assign p_addr_o      = p_addr_q;
    assign p_data_o      = p_data_q;
    assign p_data_wr_o   = p_wr_q;
    assign p_data_req_o  = p_req_q;
    assign grant_o       = grant_q;
    assign timeout_o     = timeout_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_tpm_if_arbiter.sv
// Directed vector table plus hand sequences for tie, pending/overflow, timeout and reset.
module tb_tpm_if_arbiter;

    typedef struct packed {
        logic [1:0]  grant;
        logic        pwr;
        logic        preq;
        logic [15:0] paddr;
        logic [7:0]  pdata;
        logic [1:0]  wdone;
        logic [1:0]  rd;
        logic [7:0]  rdata;
        logic        tmo;
        logic        ovf;
    } out_t;

    typedef struct {
        logic [1:0] act;
        logic [1:0] wr;
        logic [1:0] rq;
        logic       pwd;
        logic       prd;
        logic [7:0] pd;
        out_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  act, wr, rq;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        pwd, prd;
    logic [7:0]  pd;
    logic [1:0]  wdone, rd, grant;
    logic [7:0]  rdata, pdata;
    logic [15:0] paddr;
    logic        pwr, preq, tmo, ovf;

    int checks = 0;
    int errors = 0;

    tpm_if_arbiter #(.TIMEOUT_CYCLES(1024), .CNT_W(11)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_active_i   (act),
        .req_addr_i     (addr),
        .req_data_i     (wdata),
        .req_data_wr_i  (wr),
        .req_wr_done_o  (wdone),
        .req_data_o     (rdata),
        .req_data_req_i (rq),
        .req_data_rd_o  (rd),
        .p_addr_o       (paddr),
        .p_data_o       (pdata),
        .p_data_wr_o    (pwr),
        .p_wr_done_i    (pwd),
        .p_data_i       (pd),
        .p_data_rd_i    (prd),
        .p_data_req_o   (preq),
        .grant_o        (grant),
        .timeout_o      (tmo),
        .overflow_o     (ovf)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o = '{grant: grant, pwr: pwr, preq: preq, paddr: paddr, pdata: pdata,
              wdone: wdone, rd: rd, rdata: rdata, tmo: tmo, ovf: ovf};
        return o;
    endfunction

    function automatic vec_t mk(input logic [1:0] a, input logic [1:0] w, input logic [1:0] r,
                                input logic dn, input logic dr, input logic [7:0] d,
                                input logic [1:0] eg, input logic ew, input logic eq,
                                input logic [15:0] ea, input logic [7:0] ed,
                                input logic [1:0] ewd, input logic [1:0] erd, input logic [7:0] erdat);
        vec_t v;
        v.act = a; v.wr = w; v.rq = r; v.pwd = dn; v.prd = dr; v.pd = d;
        v.exp = '{grant: eg, pwr: ew, preq: eq, paddr: ea, pdata: ed,
                  wdone: ewd, rd: erd, rdata: erdat, tmo: 1'b0, ovf: 1'b0};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        act = '0; wr = '0; rq = '0; pwd = 1'b0; prd = 1'b0; pd = '0;
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    vec_t vt[14];
    out_t o;
    int   n;

    initial begin
        addr  = {16'h0018, 16'h0F00};
        wdata = {8'hA5, 8'h5A};
        rst = 1'b1;
        act = '0; wr = '0; rq = '0; pwd = 1'b0; prd = 1'b0; pd = '0;
        #3;
        check("reset_outputs", 64'(sample()), 64'(out_t'('0)));
        tick();
        #2 rst = 1'b0;
        tick();

        //        act    wr     rq    pwd   prd   pd      grant  pwr   preq  paddr     pdata  wdone  rd     rdata
        vt[0]  = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00, 2'b00, 8'h00);
        vt[1]  = mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00, 2'b00, 8'h00);
        vt[2]  = mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 16'h0F00, 8'h5A, 2'b00, 2'b00, 8'h00);
        vt[3]  = mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 16'h0F00, 8'h5A, 2'b00, 2'b00, 8'h00);
        vt[4]  = mk(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 16'h0F00, 8'h5A, 2'b01, 2'b00, 8'h00);
        vt[5]  = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 16'h0F00, 8'h5A, 2'b00, 2'b00, 8'h00);
        vt[6]  = mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0F00, 8'h5A, 2'b00, 2'b00, 8'h00);
        vt[7]  = mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 16'h0F00, 8'h5A, 2'b00, 2'b00, 8'h00);
        vt[8]  = mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 16'h0F00, 8'h5A, 2'b00, 2'b00, 8'h00);
        vt[9]  = mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 1'b1, 16'h0018, 8'h5A, 2'b00, 2'b00, 8'h00);
        vt[10] = mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 8'h3C, 2'b10, 1'b0, 1'b0, 16'h0018, 8'h5A, 2'b00, 2'b10, 8'h3C);
        vt[11] = mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 8'h3C, 2'b10, 1'b0, 1'b0, 16'h0018, 8'h5A, 2'b00, 2'b10, 8'h3C);
        vt[12] = mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 16'h0018, 8'h5A, 2'b00, 2'b00, 8'h3C);
        vt[13] = mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0018, 8'h5A, 2'b00, 2'b00, 8'h3C);

        for (int i = 0; i < 14; i++) begin
            act = vt[i].act; wr = vt[i].wr; rq = vt[i].rq;
            pwd = vt[i].pwd; prd = vt[i].prd; pd = vt[i].pd;
            tick();
            check($sformatf("vec%0d", i), 64'(sample()), 64'(vt[i].exp));
        end

        // Tie straight after reset, then handover two cycles after release.
        do_reset();
        act = 2'b11;
        tick();
        check("tie_grant", 64'(grant), 64'(2'b01));
        act = 2'b10;
        tick();
        check("release_idle", 64'(grant), 64'(2'b00));
        tick();
        check("handover_grant", 64'(grant), 64'(2'b10));

        // SPI write while LPC owns, second SPI write overflows, served after handover.
        do_reset();
        act = 2'b01;
        tick();
        act = 2'b11; wr = 2'b10;
        tick();
        wr = 2'b00;
        tick();
        check("no_overflow_yet", 64'(ovf), 64'(1'b0));
        wr = 2'b10;
        tick();
        check("overflow_set", 64'(ovf), 64'(1'b1));
        act = 2'b10; wr = 2'b00;
        tick();
        tick();
        check("pend_grant", 64'(grant), 64'(2'b10));
        tick();
        check("pend_strobe", 64'({pwr, paddr, pdata}), 64'({1'b1, 16'h0018, 8'hA5}));
        pwd = 1'b1;
        tick();
        pwd = 1'b0;
        check("pend_wr_done", 64'({wdone, pwr, ovf}), 64'({2'b10, 1'b0, 1'b1}));

        // Read with a provider that never answers.
        do_reset();
        act = 2'b01;
        tick();
        rq = 2'b01;
        tick();
        tick();
        check("rd_strobe", 64'({preq, paddr}), 64'({1'b1, 16'h0F00}));
        n = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (tmo) begin
                n = k;
                break;
            end
        end
        check("timeout_cycles", 64'(n), 64'(1024));
        check("timeout_read", 64'({preq, rd, rdata}), 64'({1'b0, 2'b01, 8'hFF}));
        tick();
        check("timeout_pulse_end", 64'({tmo, rd}), 64'({1'b0, 2'b01}));
        rq = 2'b00;
        tick();
        check("timeout_rd_release", 64'(rd), 64'(2'b00));

        // Reset asserted while a write is outstanding.
        do_reset();
        act = 2'b01; wr = 2'b01;
        tick();
        tick();
        check("wr_before_reset", 64'(pwr), 64'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("async_reset", 64'(sample()), 64'(out_t'('0)));
        act = 2'b00; wr = 2'b00;
        #3 rst = 1'b0;
        tick();
        check("after_reset_idle", 64'(sample()), 64'(out_t'('0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
